// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns the program counter and the IF/ID pipeline register, and applies
// stall/flush controls and PC redirects. Also keeps saturating stall and flush counters.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 PCWrite,
  input  logic                 DecodeRegWrite,
  input  logic                 flushControl,
  input  logic                 RedirectValid,
  input  logic [31:0]          RedirectTarget,
  input  logic [31:0]          InstrIn,
  output logic [31:0]          PCOut,
  output logic [31:0]          InstrID,
  output logic [31:0]          PCPlus4ID,
  output logic                 ValidID,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  logic [31:0]          r_pc;
  logic [31:0]          r_instr_id;
  logic [31:0]          r_pc_plus4_id;
  logic                 r_valid_id;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic [31:0]          w_pc_plus4;
  logic [31:0]          w_redirect_pc;
  logic                 w_flush_applied;
  logic                 w_stall_sat;
  logic                 w_flush_sat;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_redirect_pc   = {RedirectTarget[31:2], 2'b00};
  assign w_flush_applied = flushControl && DecodeRegWrite;
  assign w_stall_sat     = &r_stall_cnt;
  assign w_flush_sat     = &r_flush_cnt;

  // A redirect presented while PCWrite=0 is dropped; the branch re-presents it later.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc <= RESET_PC;
    end else if (PCWrite) begin
      r_pc <= RedirectValid ? w_redirect_pc : w_pc_plus4;
    end
  end

  // Hold takes priority over flush so a stalled decode instruction is never lost.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_instr_id    <= '0;
      r_pc_plus4_id <= '0;
      r_valid_id    <= 1'b0;
    end else if (DecodeRegWrite) begin
      r_pc_plus4_id <= w_pc_plus4;
      if (flushControl) begin
        r_instr_id <= '0;
        r_valid_id <= 1'b0;
      end else begin
        r_instr_id <= InstrIn;
        r_valid_id <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!PCWrite && !w_stall_sat) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
      if (w_flush_applied && !w_flush_sat) begin
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign PCOut      = r_pc;
  assign InstrID    = r_instr_id;
  assign PCPlus4ID  = r_pc_plus4_id;
  assign ValidID    = r_valid_id;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: two instances (default parameters, and wrap-PC with 4-bit
// counters) share control stimulus and are compared against a cycle-level reference model.
module tb_fetch_stage_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        PCWrite;
  logic        DecodeRegWrite;
  logic        flushControl;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;

  logic [31:0] pc0, instr_id0, p4_id0, instr_in0;
  logic        valid0;
  logic [15:0] sc0, fc0;
  logic [31:0] pc1, instr_id1, p4_id1, instr_in1;
  logic        valid1;
  logic [3:0]  sc1, fc1;

  int tests = 0;
  int fails = 0;

  // Reference model state, index 0 = default instance, index 1 = wrap/saturation instance
  logic [31:0] m_pc[2], m_ins[2], m_p4[2];
  logic        m_v[2];
  int          m_sc[2], m_fc[2];
  logic [31:0] m_rst_pc[2];
  int          m_cmax[2];

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  assign instr_in0 = rom(pc0);
  assign instr_in1 = rom(pc1);

  always #5 Clk = ~Clk;

  fetch_stage_ctrl dut0 (
    .Clk(Clk), .Rst(Rst), .PCWrite(PCWrite), .DecodeRegWrite(DecodeRegWrite),
    .flushControl(flushControl), .RedirectValid(RedirectValid),
    .RedirectTarget(RedirectTarget), .InstrIn(instr_in0),
    .PCOut(pc0), .InstrID(instr_id0), .PCPlus4ID(p4_id0), .ValidID(valid0),
    .StallCount(sc0), .FlushCount(fc0)
  );

  fetch_stage_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_WIDTH(4)) dut1 (
    .Clk(Clk), .Rst(Rst), .PCWrite(PCWrite), .DecodeRegWrite(DecodeRegWrite),
    .flushControl(flushControl), .RedirectValid(RedirectValid),
    .RedirectTarget(RedirectTarget), .InstrIn(instr_in1),
    .PCOut(pc1), .InstrID(instr_id1), .PCPlus4ID(p4_id1), .ValidID(valid1),
    .StallCount(sc1), .FlushCount(fc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next state computed from the rules, using the model's own pre-edge state
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] seq_pc;
      seq_pc = m_pc[i] + 32'd4;
      if (Rst) begin
        m_pc[i] = m_rst_pc[i];
        m_ins[i] = 0; m_p4[i] = 0; m_v[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        if (DecodeRegWrite) begin
          m_p4[i]  = seq_pc;
          m_ins[i] = flushControl ? 32'd0 : rom(m_pc[i]);
          m_v[i]   = !flushControl;
          if (flushControl && m_fc[i] < m_cmax[i]) m_fc[i]++;
        end
        if (!PCWrite && m_sc[i] < m_cmax[i]) m_sc[i]++;
        if (PCWrite) m_pc[i] = RedirectValid ? (RedirectTarget & ~32'd3) : seq_pc;
      end
    end
  endtask

  task automatic compare_all();
    check("pc0",    pc0,        m_pc[0]);
    check("instr0", instr_id0,  m_ins[0]);
    check("p4id0",  p4_id0,     m_p4[0]);
    check("valid0", {31'd0, valid0}, {31'd0, m_v[0]});
    check("stall0", {16'd0, sc0}, 32'(m_sc[0]));
    check("flush0", {16'd0, fc0}, 32'(m_fc[0]));
    check("pc1",    pc1,        m_pc[1]);
    check("instr1", instr_id1,  m_ins[1]);
    check("p4id1",  p4_id1,     m_p4[1]);
    check("valid1", {31'd0, valid1}, {31'd0, m_v[1]});
    check("stall1", {28'd0, sc1}, 32'(m_sc[1]));
    check("flush1", {28'd0, fc1}, 32'(m_fc[1]));
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic rst, input logic pcw, input logic drw, input logic fl,
                       input logic rv, input logic [31:0] tgt);
    Rst = rst; PCWrite = pcw; DecodeRegWrite = drw; flushControl = fl;
    RedirectValid = rv; RedirectTarget = tgt;
  endtask

  initial begin
    logic [31:0] saved_ins;
    m_rst_pc[0] = 32'h0;         m_cmax[0] = 65535;
    m_rst_pc[1] = 32'hFFFF_FFFC; m_cmax[1] = 15;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 'x; m_ins[i] = 'x; m_p4[i] = 'x; m_v[i] = 1'bx; m_sc[i] = 0; m_fc[i] = 0;
    end

    drive(1, 0, 0, 0, 0, 0);
    @(negedge Clk);
    cycle();
    check("rst_pc0", pc0, 32'h0);
    check("rst_pc1", pc1, 32'hFFFF_FFFC);

    // Free run from reset
    drive(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("freerun_pc", pc0, 32'(4 * (k + 1)));
    end
    check("wrap_pc1", pc1, 32'hC);

    // Stall for three cycles at PC 0x10
    saved_ins = instr_id0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    check("stall_pc", pc0, 32'h10);
    check("stall_hold_ins", instr_id0, saved_ins);
    check("stall_cnt", {16'd0, sc0}, 32'd3);
    drive(0, 1, 1, 0, 0, 0);
    repeat (4) cycle();
    check("resume_pc", pc0, 32'h20);

    // Redirect with flush at PC 0x20
    drive(0, 1, 1, 1, 1, 32'h103);
    cycle();
    check("redir_pc", pc0, 32'h100);
    check("redir_ins", instr_id0, 32'h0);
    check("flush_cnt", {16'd0, fc0}, 32'd1);
    drive(0, 1, 1, 0, 0, 0);
    cycle();
    check("redir_fetch", instr_id0, rom(32'h100));

    // Hold beats flush; redirect gated by PCWrite
    saved_ins = instr_id0;
    drive(0, 0, 0, 1, 1, 32'h4000);
    cycle();
    check("hold_ins", instr_id0, saved_ins);
    check("hold_pc", pc0, 32'h104);
    check("hold_fcnt", {16'd0, fc0}, 32'd1);

    // Saturation of the 4-bit stall counter
    drive(0, 0, 0, 0, 0, 0);
    repeat (20) cycle();
    check("sat_cnt1", {28'd0, sc1}, 32'd15);

    // Randomized traffic with occasional reset
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom);
      cycle();
    end

    // Reset during a redirect overrides it
    drive(0, 1, 1, 0, 0, 0);
    repeat (3) cycle();
    drive(1, 1, 1, 1, 1, 32'h8000);
    cycle();
    check("rst_redir_pc0", pc0, 32'h0);
    check("rst_redir_pc1", pc1, 32'hFFFF_FFFC);
    check("rst_redir_v",   {31'd0, valid0}, 32'd0);
    drive(0, 1, 1, 0, 0, 0);
    cycle();
    check("wrap_to_zero", pc1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
